alu_ex_stage: RTL and testbench

ALU_EX_STAGE -- requirements
Module: alu_ex_stage

---
 rtl/alu_ex_stage.sv | 118 +++++++++++
 tb/tb_alu_ex_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_ex_stage.sv
// Single-cycle ALU execute stage: saturating add/sub, packed nibble add, shifts and rotates.
// The result and {Z,V,N} flags are registered; a stall freezes them, and reset clears them.
module alu_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        stall,
  input  logic [3:0]  opcode,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [3:0]  imm,
  output logic        out_valid,
  output logic [15:0] result,
  output logic [2:0]  flags
);

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111
  } op_e;

  logic [16:0] sum17;
  logic [16:0] diff17;
  logic [9:0]  red10;
  logic [4:0]  lane_sum;
  logic [15:0] res_next;
  logic        z_upd;
  logic        vn_upd;
  logic        v_next;
  logic [2:0]  flags_next;

  always_comb begin
    res_next = 16'h0000;
    z_upd    = 1'b0;
    vn_upd   = 1'b0;
    v_next   = 1'b0;
    lane_sum = 5'd0;
    sum17    = {A[15], A} + {B[15], B};
    diff17   = {A[15], A} - {B[15], B};
    red10    = {{2{A[15]}}, A[15:8]} + {{2{B[15]}}, B[15:8]}
             + {{2{A[7]}}, A[7:0]}   + {{2{B[7]}}, B[7:0]};

    case (opcode)
      OP_ADD: begin
        // A mismatch between the two top bits of the 17-bit sum means overflow.
        v_next   = sum17[16] ^ sum17[15];
        res_next = v_next ? (sum17[16] ? 16'h8000 : 16'h7FFF) : sum17[15:0];
        z_upd    = 1'b1;
        vn_upd   = 1'b1;
      end
      OP_SUB: begin
        v_next   = diff17[16] ^ diff17[15];
        res_next = v_next ? (diff17[16] ? 16'h8000 : 16'h7FFF) : diff17[15:0];
        z_upd    = 1'b1;
        vn_upd   = 1'b1;
      end
      OP_XOR: begin
        res_next = A ^ B;
        z_upd    = 1'b1;
      end
      OP_RED: res_next = {{6{red10[9]}}, red10};
      OP_SLL: begin
        res_next = A << imm;
        z_upd    = 1'b1;
      end
      OP_SRA: begin
        res_next = $signed(A) >>> imm;
        z_upd    = 1'b1;
      end
      OP_ROR: begin
        // A 16-bit left shift by 16 yields zero, so imm=0 returns A unchanged.
        res_next = (A >> imm) | (A << (5'd16 - {1'b0, imm}));
        z_upd    = 1'b1;
      end
      OP_PADDSB: begin
        for (int i = 0; i < 4; i++) begin
          lane_sum = {A[4*i+3], A[4*i +: 4]} + {B[4*i+3], B[4*i +: 4]};
          if (lane_sum[4] ^ lane_sum[3])
            res_next[4*i +: 4] = lane_sum[4] ? 4'h8 : 4'h7;
          else
            res_next[4*i +: 4] = lane_sum[3:0];
        end
      end
      default: res_next = 16'h0000;
    endcase

    flags_next = flags;
    if (z_upd)
      flags_next[2] = (res_next == 16'h0000);
    if (vn_upd) begin
      flags_next[1] = v_next;
      flags_next[0] = res_next[15];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= 16'h0000;
      out_valid <= 1'b0;
      flags     <= 3'b000;
    end else if (!stall) begin
      if (in_valid) begin
        result    <= res_next;
        out_valid <= 1'b1;
        flags     <= flags_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Bench for alu_ex_stage: directed corner cases, then random traffic with stall and reset,
// all compared against an arithmetic reference model of the stage.
module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall;
  logic [3:0]  opcode, imm;
  logic [15:0] A, B;
  logic        out_valid;
  logic [15:0] result;
  logic [2:0]  flags;

  int checks = 0;
  int errors = 0;

  logic        exp_valid;
  logic [15:0] exp_result;
  logic [2:0]  exp_flags;

  alu_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall),
    .opcode(opcode), .A(A), .B(B), .imm(imm),
    .out_valid(out_valid), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  // Reference: computes the architectural effect of one accepted operation.
  task automatic model_op(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] im);
    int s, ai, bi, sh;
    logic [15:0] r;
    logic [31:0] wide;
    ai = sx(int'(a), 16);
    bi = sx(int'(b), 16);
    sh = int'(im);
    r  = 16'h0000;
    case (opc)
      4'd0, 4'd1: begin
        s = (opc == 4'd0) ? ai + bi : ai - bi;
        exp_flags[1] = (s > 32767) || (s < -32768);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        r = 16'(s);
        exp_flags[2] = (r == 16'h0000);
        exp_flags[0] = (s < 0);
      end
      4'd2: begin r = a ^ b; exp_flags[2] = (r == 16'h0000); end
      4'd3: begin
        s = sx(int'(a[15:8]), 8) + sx(int'(b[15:8]), 8) + sx(int'(a[7:0]), 8) + sx(int'(b[7:0]), 8);
        r = 16'(s);
      end
      4'd4: begin wide = {16'h0, a} << sh; r = wide[15:0]; exp_flags[2] = (r == 16'h0000); end
      4'd5: begin s = ai >>> sh; r = 16'(s); exp_flags[2] = (r == 16'h0000); end
      4'd6: begin
        wide = {a, a} >> sh;
        r = wide[15:0];
        exp_flags[2] = (r == 16'h0000);
      end
      4'd7: begin
        for (int l = 0; l < 4; l++) begin
          s = sx(int'((a >> (4 * l)) & 16'hF), 4) + sx(int'((b >> (4 * l)) & 16'hF), 4);
          if (s > 7) s = 7;
          if (s < -8) s = -8;
          r = r | (16'(s & 15) << (4 * l));
        end
      end
      default: r = 16'h0000;
    endcase
    exp_result = r;
    exp_valid  = 1'b1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r_i, input logic v_i, input logic s_i, input logic [3:0] opc,
                      input logic [15:0] a, input logic [15:0] b, input logic [3:0] im,
                      input string tag);
    rst = r_i; in_valid = v_i; stall = s_i; opcode = opc; A = a; B = b; imm = im;
    @(posedge clk);
    #1;
    if (r_i) begin
      exp_result = 16'h0000; exp_valid = 1'b0; exp_flags = 3'b000;
    end else if (!s_i) begin
      if (v_i) model_op(opc, a, b, im);
      else exp_valid = 1'b0;
    end
    check({tag, ".result"}, result, exp_result);
    check({tag, ".flags"}, {13'h0, flags}, {13'h0, exp_flags});
    check({tag, ".valid"}, {15'h0, out_valid}, {15'h0, exp_valid});
  endtask

  initial begin
    exp_valid = 1'b0; exp_result = 16'h0; exp_flags = 3'b000;
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; opcode = 4'h0; A = 16'h0; B = 16'h0; imm = 4'h0;
    step(1, 0, 0, 4'h0, 16'h0, 16'h0, 4'h0, "reset0");
    step(1, 1, 0, 4'h0, 16'h1234, 16'h1, 4'h0, "reset1");
    check("reset.result_const", result, 16'h0000);

    step(0, 1, 0, 4'h0, 16'h7FF0, 16'h0020, 4'h0, "add_possat");
    check("add_possat.const", {result, 13'h0, flags}, {16'h7FFF, 13'h0, 3'b010});
    step(0, 1, 0, 4'h1, 16'h8000, 16'h0001, 4'h0, "sub_negsat");
    check("sub_negsat.const", {result, 13'h0, flags}, {16'h8000, 13'h0, 3'b011});
    step(0, 1, 0, 4'h1, 16'h1234, 16'h1234, 4'h0, "sub_zero");
    check("sub_zero.const", {result, 13'h0, flags}, {16'h0000, 13'h0, 3'b100});
    step(0, 1, 0, 4'h0, 16'h8000, 16'h8000, 4'h0, "add_negsat");
    step(0, 1, 0, 4'h7, 16'h7981, 16'h1788, 4'h0, "paddsb");
    step(0, 1, 0, 4'h6, 16'h8001, 16'h0000, 4'h1, "ror1");
    check("ror1.const", result, 16'hC000);
    step(0, 1, 0, 4'h6, 16'hA5C3, 16'h0000, 4'h0, "ror0");
    step(0, 1, 0, 4'h5, 16'h8000, 16'h0000, 4'hF, "sra15");
    check("sra15.const", result, 16'hFFFF);
    step(0, 1, 0, 4'h4, 16'h8000, 16'h0000, 4'h1, "sll_zero");
    check("sll_zero.z", {15'h0, flags[2]}, 16'h0001);
    step(0, 1, 0, 4'h3, 16'h8080, 16'h8080, 4'h0, "red_min");
    step(0, 1, 0, 4'h3, 16'h7F7F, 16'h7F7F, 4'h0, "red_max");
    step(0, 1, 0, 4'h2, 16'hFFFF, 16'h0F0F, 4'h0, "xor");
    step(0, 1, 0, 4'hB, 16'h1111, 16'h2222, 4'h3, "undef_op");

    step(0, 1, 0, 4'h0, 16'h0100, 16'h0023, 4'h0, "pre_stall");
    step(0, 1, 1, 4'h0, 16'h7FFF, 16'h7FFF, 4'h0, "stall1");
    step(0, 1, 1, 4'h1, 16'h0000, 16'h0000, 4'h0, "stall2");
    step(0, 1, 0, 4'h0, 16'h0002, 16'h0003, 4'h0, "post_stall");
    check("post_stall.const", result, 16'h0005);
    step(0, 0, 0, 4'h0, 16'hDEAD, 16'hBEEF, 4'h0, "idle");
    step(0, 1, 0, 4'h1, 16'h0001, 16'h0002, 4'h0, "pre_rst");
    step(1, 1, 1, 4'h0, 16'h7000, 16'h7000, 4'h0, "rst_stall");
    check("rst_stall.const", {result, 13'h0, flags}, {16'h0000, 13'h0, 3'b000});
    step(0, 1, 0, 4'h0, 16'h0004, 16'h0005, 4'h0, "resume");

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
           4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
           "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
